mmr_scrub_ctrl: RTL and testbench

MMR_SCRUB_CTRL -- requirements
Module: mmr_scrub_ctrl

---
 rtl/mmr_scrub_ctrl.sv | 157 +++++++++++++++
 tb/tb_mmr_scrub_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmr_scrub_ctrl.sv
// Scrub controller for cross-voted MMR groups: round-robin rewrite of mismatching groups.
// Optional periodic sweep of all groups when MMR_SCRUB_SWEEP_EN is defined.
module mmr_scrub_ctrl #(
  parameter int unsigned N_REG        = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned TIMEOUT      = 64,
  parameter int unsigned SWEEP_PERIOD = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [N_REG-1:0]         mismatch_i,
  output logic                     scrub_req_o,
  output logic [$clog2(N_REG)-1:0] scrub_idx_o,
  input  logic                     scrub_ack_i,
  input  logic                     cnt_clr_i,
  output logic [CNT_W-1:0]         scrub_cnt_o,
  output logic [N_REG-1:0]         pending_o,
  output logic                     busy_o,
  output logic                     timeout_o
);

  localparam int unsigned IDX_W = $clog2(N_REG);
  localparam int unsigned TMO_W = $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_DONE
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_idx;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [IDX_W-1:0]   rr_idx;
  logic [N_REG-1:0]   pend_nxt;
  logic               ack_hit;
  logic               tmo_hit;

`ifdef MMR_SCRUB_SWEEP_EN
  localparam int unsigned SWP_W = (SWEEP_PERIOD > 1) ? $clog2(SWEEP_PERIOD) : 1;
  localparam logic [SWP_W-1:0] SWP_LAST = SWP_W'(SWEEP_PERIOD - 1);

  logic [SWP_W-1:0] sweep_cnt;
  logic             sweep_hit;

  assign sweep_hit = (sweep_cnt == SWP_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sweep_cnt <= '0;
    end else if (sweep_hit) begin
      sweep_cnt <= '0;
    end else begin
      sweep_cnt <= sweep_cnt + 1'b1;
    end
  end
`endif

  assign ack_hit = (state == S_REQ) && scrub_ack_i;
  assign tmo_hit = (state == S_REQ) && !scrub_ack_i && (tmo_cnt == TMO_LAST);

  // First pending group strictly after last_idx, wrapping at N_REG-1.
  always_comb begin
    int unsigned c;
    logic        found;
    c      = 0;
    found  = 1'b0;
    rr_idx = last_idx;
    for (int unsigned k = 1; k <= N_REG; k++) begin
      c = 32'(last_idx) + k;
      if (c >= N_REG) c = c - N_REG;
      if (!found && pending_o[c]) begin
        rr_idx = IDX_W'(c);
        found  = 1'b1;
      end
    end
  end

  // New mismatches are ORed in after the clear so a same-cycle set wins.
  always_comb begin
    pend_nxt = pending_o;
    if (state == S_DONE) pend_nxt[scrub_idx_o] = 1'b0;
    pend_nxt = pend_nxt | mismatch_i;
`ifdef MMR_SCRUB_SWEEP_EN
    if (sweep_hit) pend_nxt = '1;
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      scrub_req_o <= 1'b0;
      scrub_idx_o <= '0;
      pending_o   <= '0;
      scrub_cnt_o <= '0;
      busy_o      <= 1'b0;
      timeout_o   <= 1'b0;
      last_idx    <= IDX_W'(N_REG - 1);
      tmo_cnt     <= '0;
    end else begin
      pending_o <= pend_nxt;

      if (cnt_clr_i) begin
        scrub_cnt_o <= '0;
      end else if (state == S_DONE && scrub_cnt_o != '1) begin
        scrub_cnt_o <= scrub_cnt_o + 1'b1;
      end

      if (cnt_clr_i) begin
        timeout_o <= 1'b0;
      end else if (tmo_hit) begin
        timeout_o <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (|pending_o) begin
            state  <= S_SELECT;
            busy_o <= 1'b1;
          end
        end
        S_SELECT: begin
          scrub_idx_o <= rr_idx;
          scrub_req_o <= 1'b1;
          tmo_cnt     <= '0;
          state       <= S_REQ;
        end
        S_REQ: begin
          if (ack_hit) begin
            scrub_req_o <= 1'b0;
            state       <= S_DONE;
          end else if (tmo_hit) begin
            scrub_req_o <= 1'b0;
            last_idx    <= scrub_idx_o;
            busy_o      <= 1'b0;
            state       <= S_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_DONE: begin
          last_idx <= scrub_idx_o;
          busy_o   <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          scrub_req_o <= 1'b0;
          busy_o      <= 1'b0;
          state       <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmr_scrub_ctrl.sv
// Directed bench for mmr_scrub_ctrl (N_REG=8, CNT_W=4, TIMEOUT=64, SWEEP_PERIOD=32).
module tb_mmr_scrub_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] mismatch_i = '0;
  logic       scrub_req_o;
  logic [2:0] scrub_idx_o;
  logic       scrub_ack_i = 1'b0;
  logic       cnt_clr_i = 1'b0;
  logic [3:0] scrub_cnt_o;
  logic [7:0] pending_o;
  logic       busy_o;
  logic       timeout_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk_i = ~clk_i;

  mmr_scrub_ctrl #(
    .N_REG       (8),
    .CNT_W       (4),
    .TIMEOUT     (64),
    .SWEEP_PERIOD(32)
  ) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .mismatch_i (mismatch_i),
    .scrub_req_o(scrub_req_o),
    .scrub_idx_o(scrub_idx_o),
    .scrub_ack_i(scrub_ack_i),
    .cnt_clr_i  (cnt_clr_i),
    .scrub_cnt_o(scrub_cnt_o),
    .pending_o  (pending_o),
    .busy_o     (busy_o),
    .timeout_o  (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i       = 1'b1;
    mismatch_i  = '0;
    scrub_ack_i = 1'b0;
    cnt_clr_i   = 1'b0;
    tick();
    tick();
    #2 rst_i = 1'b0;
    tick();
  endtask

  // Wait for a request, capture its index, acknowledge immediately.
  task automatic serve(output logic [2:0] idx);
    int unsigned n;
    n = 0;
    while (!scrub_req_o && n < 20) begin
      tick();
      n++;
    end
    if (!scrub_req_o) begin
      check("serve_wait_req", 32'(scrub_req_o), 32'd1);
      idx = 3'h7;
    end else begin
      idx = scrub_idx_o;
      scrub_ack_i = 1'b1;
      tick();
      scrub_ack_i = 1'b0;
    end
  endtask

  initial begin
    logic [2:0] idx;

    do_reset();
    check("rst_req",     32'(scrub_req_o), 32'd0);
    check("rst_idx",     32'(scrub_idx_o), 32'd0);
    check("rst_pending", 32'(pending_o),   32'd0);
    check("rst_cnt",     32'(scrub_cnt_o), 32'd0);
    check("rst_busy",    32'(busy_o),      32'd0);
    check("rst_tmo",     32'(timeout_o),   32'd0);

`ifdef MMR_SCRUB_SWEEP_EN
    for (int i = 0; i < 29; i++) tick();
    check("sweep_quiet_req",  32'(scrub_req_o), 32'd0);
    check("sweep_quiet_pend", 32'(pending_o),   32'd0);
    for (int i = 0; i < 8; i++) begin
      serve(idx);
      check($sformatf("sweep_order_%0d", i), 32'(idx), 32'(i));
    end
`else
    // Single mismatch on group 3, ack three cycles after the request.
    mismatch_i = 8'h08;
    tick();
    mismatch_i = '0;
    check("t1_pend_set", 32'(pending_o),   32'h08);
    check("t1_req_e0",   32'(scrub_req_o), 32'd0);
    tick();
    check("t1_req_e1",   32'(scrub_req_o), 32'd0);
    check("t1_busy_e1",  32'(busy_o),      32'd1);
    tick();
    check("t1_req_e2",   32'(scrub_req_o), 32'd1);
    check("t1_idx",      32'(scrub_idx_o), 32'd3);
    tick();
    tick();
    check("t1_req_hold", 32'(scrub_req_o), 32'd1);
    check("t1_idx_hold", 32'(scrub_idx_o), 32'd3);
    scrub_ack_i = 1'b1;
    tick();
    scrub_ack_i = 1'b0;
    check("t1_req_drop", 32'(scrub_req_o), 32'd0);
    tick();
    check("t1_cnt",      32'(scrub_cnt_o), 32'd1);
    check("t1_pend_clr", 32'(pending_o),   32'd0);
    check("t1_busy_end", 32'(busy_o),      32'd0);
    scrub_ack_i = 1'b1;
    tick();
    scrub_ack_i = 1'b0;
    tick();
    tick();
    check("t1_stray_ack", 32'(scrub_cnt_o), 32'd1);

    // Three groups pending at once are served in round-robin order.
    do_reset();
    mismatch_i = 8'h85;
    tick();
    mismatch_i = '0;
    serve(idx); check("t2_first",  32'(idx), 32'd0);
    serve(idx); check("t2_second", 32'(idx), 32'd2);
    serve(idx); check("t2_third",  32'(idx), 32'd7);
    tick();
    check("t2_cnt",  32'(scrub_cnt_o), 32'd3);
    check("t2_pend", 32'(pending_o),   32'd0);

    // Unanswered request times out after 64 cycles and is retried.
    do_reset();
    mismatch_i = 8'h20;
    tick();
    mismatch_i = '0;
    tick();
    tick();
    check("t3_req_up", 32'(scrub_req_o), 32'd1);
    for (int i = 0; i < 63; i++) tick();
    check("t3_req_63", 32'(scrub_req_o), 32'd1);
    check("t3_tmo_63", 32'(timeout_o),   32'd0);
    tick();
    check("t3_req_64",  32'(scrub_req_o), 32'd0);
    check("t3_tmo_set", 32'(timeout_o),   32'd1);
    check("t3_pend",    32'(pending_o),   32'h20);
    check("t3_cnt0",    32'(scrub_cnt_o), 32'd0);
    serve(idx);
    check("t3_retry_idx", 32'(idx), 32'd5);
    mismatch_i = 8'h20;
    tick();
    mismatch_i = '0;
    check("t3_set_wins", 32'(pending_o),   32'h20);
    check("t3_cnt1",     32'(scrub_cnt_o), 32'd1);
    serve(idx);
    tick();
    check("t3_pend_clr",  32'(pending_o),   32'd0);
    check("t3_tmo_stick", 32'(timeout_o),   32'd1);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    check("t3_tmo_clr", 32'(timeout_o),   32'd0);
    check("t3_cnt_clr", 32'(scrub_cnt_o), 32'd0);

    // Four-bit counter saturates; clear on the increment cycle wins.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      mismatch_i = 8'h02;
      tick();
      mismatch_i = '0;
      serve(idx);
      tick();
      if (i == 14) check("t4_cnt_15", 32'(scrub_cnt_o), 32'd15);
    end
    check("t4_cnt_sat", 32'(scrub_cnt_o), 32'd15);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    mismatch_i = 8'h10;
    tick();
    mismatch_i = '0;
    serve(idx);
    cnt_clr_i = 1'b1;
    tick();
    cnt_clr_i = 1'b0;
    check("t4_clr_inc", 32'(scrub_cnt_o), 32'd0);

    // Asynchronous reset in the middle of a request.
    do_reset();
    mismatch_i = 8'h04;
    tick();
    mismatch_i = '0;
    tick();
    tick();
    check("t5_req_up", 32'(scrub_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    check("t5_req_async",  32'(scrub_req_o), 32'd0);
    check("t5_pend_async", 32'(pending_o),   32'd0);
    check("t5_busy_async", 32'(busy_o),      32'd0);
    #1 rst_i = 1'b0;
    tick();
    tick();
    check("t5_stay_idle", 32'(busy_o), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
